// File: rtl/full_adder_behav_four.sv
// ---------------------------------------------------------------------------
// full_adder_behav_four
//
// Purpose:
//   Small ripple-carry adder computing {Cout, Sum} = A + B + Cin.
//   It also produces a signed-overflow flag and a zero flag.
//   The adder is a generate chain of per-bit full-adder cells.
//   Each cell computes:
//     s  = a ^ b ^ c
//     co = a&b | c&(a^b)
//   The result wraps modulo 2^WIDTH and is never saturated.
//
// Configuration:
//   FA4_REG_OUT_EN  undefined (default build):
//                     Purely combinational. clk and rst_n are ignored.
//                   defined:
//                     Sum/Cout/Ovf/Zero are registered on posedge clk,
//                     giving 1-cycle latency.
//                     rst_n low immediately forces Sum=0, Cout=0, Ovf=0, Zero=1.
//
// Parameters:
//   WIDTH   operand/sum width in bits, 1..32 (default 4)
//
// Ports:
//   clk     in   1      clock (registered build only)
//   rst_n   in   1      async active-low reset (registered build only)
//   A       in   WIDTH  addend A
//   B       in   WIDTH  addend B
//   Cin     in   1      carry into bit 0
//   Sum     out  WIDTH  (A + B + Cin) mod 2^WIDTH
//   Cout    out  1      carry out of the MSB
//   Ovf     out  1      signed overflow: carry into MSB ^ carry out of MSB
//   Zero    out  1      1 when Sum == 0 (Cout is not considered)
// ---------------------------------------------------------------------------
module full_adder_behav_four #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sumComb;
    logic             coutComb;
    logic             ovfComb;
    logic             zeroComb;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : gBit
            assign sumComb[i]  = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1]  = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign coutComb = carry[WIDTH];
    // A signed overflow occurs exactly when the carry into the sign bit
    // differs from the carry out of it.
    assign ovfComb  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zeroComb = ~|sumComb;

`ifdef FA4_REG_OUT_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    always_comb begin
        sum_d  = sumComb;
        cout_d = coutComb;
        ovf_d  = ovfComb;
        zero_d = zeroComb;
    end

    // Zero resets to 1 so the flags stay consistent with the reset Sum of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign Zero = zero_q;
`else
    // clk and rst_n have no function in the combinational build.
    // They are folded into one deliberately unused net.
    logic unusedInputs;
    assign unusedInputs = clk ^ rst_n;

    assign Sum  = sumComb;
    assign Cout = coutComb;
    assign Ovf  = ovfComb;
    assign Zero = zeroComb;
`endif

endmodule

// File: tb/tb_full_adder_behav_four.sv
// ---------------------------------------------------------------------------
// tb_full_adder_behav_four
//
// Purpose:
//   Self-checking bench for full_adder_behav_four in its default,
//   combinational build (FA4_REG_OUT_EN undefined).
//
// Method:
//   Each step drives A/B/Cin and pushes the expected
//   {Sum, Cout, Ovf, Zero} onto a scoreboard queue.
//   The expected value comes from a reference model written independently
//   of the carry chain.
//   The DUT outputs are then sampled away from the clock edge, and the
//   oldest queue entry is popped and compared.
//
// Ports of DUT:
//   clk, rst_n, A, B, Cin -> Sum, Cout, Ovf, Zero
// ---------------------------------------------------------------------------
module tb_full_adder_behav_four;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       Ovf;
    logic       Zero;

    typedef struct {
        string      tag;
        logic [6:0] expVal;
    } scoreEntry_t;

    scoreEntry_t scoreboard[$];
    int          passCount;
    int          checkCount;

    full_adder_behav_four #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, packed as {Sum[3:0], Cout, Ovf, Zero}.
    // Overflow here uses the sign rule: the operands share a sign and the
    // result's sign differs from it.
    function automatic logic [6:0] model(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       cin);
        logic [4:0] full;
        logic       ovf;
        logic       zero;
        full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        ovf  = (a[3] == b[3]) && (full[3] != a[3]);
        zero = (full[3:0] == 4'h0);
        return {full[3:0], full[4], ovf, zero};
    endfunction

    // Drives the inputs at the falling edge and records the expectation.
    task automatic applyStimulus(input string tag, input logic [3:0] a,
                                 input logic [3:0] b, input logic cin);
        scoreEntry_t entry;
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        entry.tag    = tag;
        entry.expVal = model(a, b, cin);
        scoreboard.push_back(entry);
    endtask

    // Samples the outputs shortly after the inputs change, well away from
    // the rising edge, and compares them against the oldest expectation.
    task automatic checkOutput();
        scoreEntry_t entry;
        logic [6:0]  observed;
        #2;
        observed = {Sum, Cout, Ovf, Zero};
        checkCount++;
        if (scoreboard.size() == 0) begin
            $error("[TB] FAIL scoreboard_empty: got %b required a queued expectation", observed);
        end else begin
            entry = scoreboard.pop_front();
            assert (observed === entry.expVal) passCount++;
            else $error("[TB] FAIL %s: A=%h B=%h Cin=%b got {Sum,Cout,Ovf,Zero}=%b required %b",
                        entry.tag, A, B, Cin, observed, entry.expVal);
        end
    endtask

    initial begin
        logic [8:0] vec;
        passCount  = 0;
        checkCount = 0;
        rst_n = 1'b0;
        A     = 4'h0;
        B     = 4'h0;
        Cin   = 1'b0;

        // Reset is held low. The combinational build must still add.
        applyStimulus("rst_low_zero", 4'h0, 4'h0, 1'b0); checkOutput();
        applyStimulus("rst_low_add",  4'h3, 4'h4, 1'b1); checkOutput();
        rst_n = 1'b1;

        applyStimulus("zero_zero",  4'h0, 4'h0, 1'b0); checkOutput();
        applyStimulus("pos_ovf",    4'h5, 4'h5, 1'b1); checkOutput();
        applyStimulus("one",        4'h0, 4'h1, 1'b0); checkOutput();
        applyStimulus("all_ones",   4'hF, 4'hF, 1'b1); checkOutput();
        applyStimulus("neg_wrap",   4'h8, 4'h8, 1'b0); checkOutput();
        applyStimulus("seven_one",  4'h7, 4'h1, 1'b0); checkOutput();
        applyStimulus("carry_only", 4'hF, 4'h0, 1'b1); checkOutput();

        // Exhaustive sweep of every A/B/Cin combination, one per 10 time units.
        for (int v = 0; v < 512; v++) begin
            vec = v[8:0];
            applyStimulus("exhaustive", vec[8:5], vec[4:1], vec[0]);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
